// File: rtl/key_event_decoder.sv
// key_event_decoder
//   Sits between the UART receiver and the game Machine FSM. Received key
//   bytes are turned into held movement directions (so movement survives the
//   UART key-repeat gap) and a small queue of action commands (so presses are
//   not lost while Machine is busy). The last received byte is republished on
//   `key` for existing consumers. Every output comes from a register; there is
//   no combinational path from rx_* to any output.
//
// Ports
//   clk         system clock (100 MHz)
//   reset_n     synchronous, active-low reset
//   rx_data     byte from the UART receiver
//   rx_valid    one-cycle strobe, rx_data valid this cycle
//   key         last byte received, unfolded
//   move_dir    held directions {up, down, left, right} = bits [3:0]
//   act_valid   action queue non-empty
//   act_code    head action: 0 confirm, 1 cancel, 2 heal (0 when empty)
//   act_ready   consumer accepts the head action
//   drop_pulse  one-cycle pulse: an action was discarded because the queue was full
//
// Handshake: the head entry transfers on a clk edge where act_valid and
// act_ready are both 1. act_code is held stable while act_valid=1 and
// act_ready=0; act_ready while act_valid=0 has no effect.
module key_event_decoder #(
    parameter int HOLD_CYCLES = 5_000_000,
    parameter int DEPTH       = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] key,
    output logic [3:0] move_dir,
    output logic       act_valid,
    output logic [1:0] act_code,
    input  logic       act_ready,
    output logic       drop_pulse
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES);
    localparam logic [NW-1:0] DEPTH_N   = NW'(DEPTH);

    // ------------------------------------------------------------------
    // Byte classification (lower-case letters folded to upper case)
    // ------------------------------------------------------------------
    logic [7:0] folded;
    logic [3:0] dirPress;
    logic       actPress;
    logic [1:0] actCode;

    always_comb begin
        folded   = rx_data;
        dirPress = 4'b0000;
        actPress = 1'b0;
        actCode  = 2'd0;
        if (rx_data >= 8'h61 && rx_data <= 8'h7A) begin
            folded = rx_data & 8'hDF;
        end
        if (rx_valid) begin
            case (folded)
                8'h57: dirPress[3] = 1'b1;              // W up
                8'h53: dirPress[2] = 1'b1;              // S down
                8'h41: dirPress[1] = 1'b1;              // A left
                8'h44: dirPress[0] = 1'b1;              // D right
                8'h20, 8'h0D: begin                     // space / CR confirm
                    actPress = 1'b1;
                    actCode  = 2'd0;
                end
                8'h58: begin                            // X cancel
                    actPress = 1'b1;
                    actCode  = 2'd1;
                end
                8'h48: begin                            // H heal
                    actPress = 1'b1;
                    actCode  = 2'd2;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            key <= 8'h00;
        end else if (rx_valid) begin
            key <= rx_data;
        end
    end

    // ------------------------------------------------------------------
    // Direction hold counters. Bit pairs {3,2} and {1,0} are opposites,
    // so the opposite of bit i is bit i^1: pressing one clears the other
    // in the same edge, giving no overlap cycle.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < 4; i++) begin : gHold
        logic [CW-1:0] holdCnt;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                holdCnt <= '0;
            end else if (dirPress[i]) begin
                holdCnt <= HOLD_LOAD;
            end else if (dirPress[i ^ 1]) begin
                holdCnt <= '0;
            end else if (holdCnt != '0) begin
                holdCnt <= holdCnt - CW'(1);
            end
        end

        assign move_dir[i] = (holdCnt != '0);
    end

    // ------------------------------------------------------------------
    // Action queue: circular buffer, pointers wrap naturally (DEPTH is a
    // power of two). A push into a full queue is still accepted when the
    // head leaves in the same cycle.
    // ------------------------------------------------------------------
    logic [1:0]    mem [DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [NW-1:0] count;
    logic          pop;
    logic          push;
    logic          drop;

    assign act_valid = (count != '0);
    assign pop       = act_valid & act_ready;
    assign push      = actPress & ((count < DEPTH_N) | pop);
    assign drop      = actPress & ~push;
    assign act_code  = act_valid ? mem[rdPtr] : 2'd0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdPtr      <= '0;
            wrPtr      <= '0;
            count      <= '0;
            drop_pulse <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
            drop_pulse <= drop;
        end
    end

    // Storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            mem[wrPtr] <= actCode;
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder with HOLD_CYCLES=8, DEPTH=4. A reference model
// keeps per-direction expiry times and an action queue; every cycle all
// outputs are compared against it. Directed scenarios run first, then random
// traffic with occasional resets.
module tb_key_event_decoder;

    localparam int HOLD  = 8;
    localparam int DEPTH = 4;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       act_ready = 1'b0;
    logic [7:0] key;
    logic [3:0] move_dir;
    logic       act_valid;
    logic [1:0] act_code;
    logic       drop_pulse;

    always #5 clk = ~clk;

    key_event_decoder #(.HOLD_CYCLES(HOLD), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .key       (key),
        .move_dir  (move_dir),
        .act_valid (act_valid),
        .act_code  (act_code),
        .act_ready (act_ready),
        .drop_pulse(drop_pulse)
    );

    // ---------------- scoreboard / model state ----------------
    int         checks = 0;
    int         failures = 0;
    logic [1:0] exp_q[$];
    int         edgeNum = 0;
    int         expiry[4];
    logic [7:0] keyModel = 8'h00;
    logic       dropModel = 1'b0;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Direction index for a byte: 3 up, 2 down, 1 left, 0 right, -1 none.
    function automatic int dirIndex(input logic [7:0] b);
        case (b)
            8'h57, 8'h77: return 3;
            8'h53, 8'h73: return 2;
            8'h41, 8'h61: return 1;
            8'h44, 8'h64: return 0;
            default:      return -1;
        endcase
    endfunction

    // Action code for a byte, -1 when the byte is not an action.
    function automatic int actionOf(input logic [7:0] b);
        case (b)
            8'h20, 8'h0D: return 0;
            8'h58, 8'h78: return 1;
            8'h48, 8'h68: return 2;
            default:      return -1;
        endcase
    endfunction

    // Model of one clock edge. A direction pressed at edge k stays asserted
    // after edges k .. k+HOLD-1, i.e. while edgeNum <= expiry.
    task automatic modelEdge(input logic rstn, input logic rxv, input logic [7:0] data, input logic rdy);
        int  d;
        int  a;
        bit  pop;
        bit  room;
        if (!rstn) begin
            keyModel  = 8'h00;
            dropModel = 1'b0;
            exp_q.delete();
            for (int i = 0; i < 4; i++) expiry[i] = 0;
        end else begin
            pop       = (exp_q.size() > 0) && rdy;
            room      = (exp_q.size() < DEPTH) || pop;
            a         = -1;
            dropModel = 1'b0;
            if (rxv) begin
                keyModel = data;
                d = dirIndex(data);
                if (d >= 0) begin
                    expiry[d]     = edgeNum + HOLD;
                    expiry[d ^ 1] = edgeNum;
                end
                a = actionOf(data);
            end
            if (pop) void'(exp_q.pop_front());
            if (a >= 0) begin
                if (room) exp_q.push_back(a[1:0]);
                else      dropModel = 1'b1;
            end
        end
        edgeNum++;
    endtask

    function automatic logic [3:0] expDir();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (edgeNum <= expiry[i]);
        return r;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic rstn, input logic rxv, input logic [7:0] data, input logic rdy);
        @(negedge clk);
        reset_n   = rstn;
        rx_valid  = rxv;
        rx_data   = data;
        act_ready = rdy;
        @(posedge clk);
        modelEdge(rstn, rxv, data, rdy);
        #1;
        checkValue("key", key, keyModel);
        checkValue("move_dir", move_dir, expDir());
        checkValue("act_valid", act_valid, exp_q.size() > 0);
        checkValue("act_code", act_code, (exp_q.size() > 0) ? exp_q[0] : 2'd0);
        checkValue("drop_pulse", drop_pulse, dropModel);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, rdy);
    endtask

    logic [7:0] palette[16] = '{8'h77, 8'h57, 8'h73, 8'h53, 8'h61, 8'h41, 8'h64, 8'h44,
                                8'h20, 8'h0D, 8'h78, 8'h58, 8'h68, 8'h48, 8'h71, 8'h7A};

    // ---------------- stimulus ----------------
    initial begin
        int holdLen;
        for (int i = 0; i < 4; i++) expiry[i] = 0;

        // Reset with 'w' strobes that must be ignored.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h77, 1'b0);
        idle(2, 1'b0);

        // Single 'd': exactly HOLD asserted cycles.
        holdLen = 0;
        step(1'b1, 1'b1, 8'h64, 1'b0);
        checkValue("key_d", key, 8'h64);
        if (move_dir[0]) holdLen++;
        for (int i = 0; i < 11; i++) begin
            idle(1, 1'b0);
            if (move_dir[0]) holdLen++;
        end
        checkValue("hold_len", holdLen, HOLD);

        // Re-press 'D' at cycle 5: continuous through 13 cycles.
        holdLen = 0;
        step(1'b1, 1'b1, 8'h64, 1'b0);
        if (move_dir[0]) holdLen++;
        for (int i = 1; i < 18; i++) begin
            if (i == 5) step(1'b1, 1'b1, 8'h44, 1'b0);
            else        idle(1, 1'b0);
            if (move_dir[0]) holdLen++;
        end
        checkValue("rehold_len", holdLen, 13);

        // Opposite cancel and an unmapped byte.
        step(1'b1, 1'b1, 8'h77, 1'b0);
        idle(1, 1'b0);
        step(1'b1, 1'b1, 8'h73, 1'b0);
        checkValue("cancel_dir", move_dir, 4'b0100);
        step(1'b1, 1'b1, 8'h71, 1'b0);
        idle(10, 1'b0);

        // FIFO order, then drain.
        step(1'b1, 1'b1, 8'h20, 1'b0);
        step(1'b1, 1'b1, 8'h78, 1'b0);
        step(1'b1, 1'b1, 8'h68, 1'b0);
        step(1'b1, 1'b1, 8'h0D, 1'b0);
        idle(2, 1'b0);
        idle(6, 1'b1);

        // Overflow: drop when full, accept when popping in the same cycle.
        step(1'b1, 1'b1, 8'h20, 1'b0);
        step(1'b1, 1'b1, 8'h58, 1'b0);
        step(1'b1, 1'b1, 8'h58, 1'b0);
        step(1'b1, 1'b1, 8'h0D, 1'b0);
        step(1'b1, 1'b1, 8'h68, 1'b0);
        checkValue("drop_full", drop_pulse, 1'b1);
        idle(1, 1'b0);
        step(1'b1, 1'b1, 8'h68, 1'b1);
        checkValue("no_drop_pop", drop_pulse, 1'b0);
        idle(6, 1'b1);

        // Reset mid-operation.
        step(1'b1, 1'b1, 8'h20, 1'b0);
        step(1'b1, 1'b1, 8'h78, 1'b0);
        step(1'b1, 1'b1, 8'h48, 1'b0);
        step(1'b1, 1'b1, 8'h61, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        checkValue("rst_valid", act_valid, 1'b0);
        step(1'b1, 1'b1, 8'h68, 1'b0);
        checkValue("post_rst_code", act_code, 2'd2);
        idle(3, 1'b1);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] b;
            logic       rstn;
            b    = ($urandom_range(0, 9) < 7) ? palette[$urandom_range(0, 15)] : 8'($urandom);
            rstn = ($urandom_range(0, 199) != 0);
            step(rstn, ($urandom_range(0, 1) == 1), b, ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
